// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter: accepts one byte per valid/ready handshake and
// shifts it out LSB first at CLOCK_FREQ/BAUD_RATE clocks per bit.
module uart_tx #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       uart_in_valid,
   input  logic [7:0] uart_in,
   output logic       serial_out,
   output logic       tx_ready
);

   localparam int DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      START = 4'd1,
      DATA0 = 4'd2,
      DATA1 = 4'd3,
      DATA2 = 4'd4,
      DATA3 = 4'd5,
      DATA4 = 4'd6,
      DATA5 = 4'd7,
      DATA6 = 4'd8,
      DATA7 = 4'd9,
      STOP  = 4'd10
   } state_t;

   state_t          c_state;
   state_t          n_state;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [7:0]      data_q;
   logic [7:0]      data_d;
   logic            serial_q;
   logic            serial_d;
   logic            ready_q;
   logic            ready_d;
   logic            symbol_edge;

   assign symbol_edge = (cnt_q == CNT_LAST);

   // Next state, baud counter and data shifter
   always_comb begin
      n_state = c_state;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (c_state)
         IDLE: begin
            cnt_d = CNT_ZERO;
            if (uart_in_valid) begin
               n_state = START;
               data_d  = uart_in;
            end else begin
               n_state = IDLE;
            end
         end
         START, DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, DATA7: begin
            if (symbol_edge) begin
               cnt_d   = CNT_ZERO;
               n_state = state_t'(c_state + 4'd1);
               // bit 0 of the register always holds the data bit on the line
               if (c_state != START) begin
                  data_d = data_q >> 1;
               end else begin
                  data_d = data_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (symbol_edge) begin
               cnt_d   = CNT_ZERO;
               n_state = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            n_state = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Line level and ready decoded from the next state so both leave a flop
   always_comb begin
      serial_d = 1'b1;
      ready_d  = 1'b0;
      case (n_state)
         IDLE: begin
            serial_d = 1'b1;
            ready_d  = 1'b1;
         end
         START:   serial_d = 1'b0;
         DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, DATA7:
                  serial_d = data_d[0];
         STOP:    serial_d = 1'b1;
         default: serial_d = 1'b1;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (n_rst) begin
         c_state  <= IDLE;
         cnt_q    <= CNT_ZERO;
         data_q   <= 8'h00;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
      end else begin
         c_state  <= n_state;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
      end
   end

   assign serial_out = serial_q;
   assign tx_ready   = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (default divider 434 and divider 3), a
// time-since-acceptance line model, a bit-level receiver and directed checks.
module tb_uart_tx;

   localparam int DIV_A = 50_000_000 / 115_200;
   localparam int DIV_B = 1000 / 300;

   logic       clk = 1'b0;
   logic       rst   [2];
   logic       valid [2];
   logic [7:0] din   [2];
   logic       so    [2];
   logic       rdy   [2];
   logic [3:0] st    [2];
   logic       sym   [2];

   always #5 clk = ~clk;

   uart_tx u_a (
      .clk           (clk),
      .n_rst         (rst[0]),
      .uart_in_valid (valid[0]),
      .uart_in       (din[0]),
      .serial_out    (so[0]),
      .tx_ready      (rdy[0])
   );

   uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(300)) u_b (
      .clk           (clk),
      .n_rst         (rst[1]),
      .uart_in_valid (valid[1]),
      .uart_in       (din[1]),
      .serial_out    (so[1]),
      .tx_ready      (rdy[1])
   );

   assign st[0]  = u_a.c_state;
   assign st[1]  = u_b.c_state;
   assign sym[0] = u_a.symbol_edge;
   assign sym[1] = u_b.symbol_edge;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  sb0[$];
   logic [7:0]  sb1[$];

   // model: cycles elapsed since acceptance and the byte being sent
   bit          busy_m [2];
   int          k_m    [2];
   logic [7:0]  b_m    [2];

   // receiver state
   int          nb     [2];
   int          run    [2];
   logic [3:0]  pst    [2];
   logic [9:0]  fr     [2];
   logic [9:0]  lastfr [2];
   int          rxcnt  [2];

   function automatic int dv(input int i);
      return (i == 0) ? DIV_A : DIV_B;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model advances on each rising edge
   initial begin
      busy_m = '{1'b0, 1'b0};
      k_m    = '{0, 0};
      b_m    = '{8'h00, 8'h00};
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst[i] === 1'b1) begin
               busy_m[i] = 1'b0;
            end else if (!busy_m[i]) begin
               if (valid[i] === 1'b1) begin
                  busy_m[i] = 1'b1;
                  k_m[i]    = 0;
                  b_m[i]    = din[i];
               end
            end else begin
               k_m[i]++;
               if (k_m[i] == 10 * dv(i)) busy_m[i] = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus bit-level receiver
   initial begin
      int         d, pos;
      logic       e_so, e_rdy, e_sym;
      logic [3:0] e_st;
      logic [7:0] exp_b;
      nb = '{0, 0}; run = '{0, 0}; rxcnt = '{0, 0};
      pst = '{4'd0, 4'd0}; fr = '{10'd0, 10'd0}; lastfr = '{10'd0, 10'd0};
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               d = dv(i);
               if (busy_m[i]) begin
                  pos   = k_m[i] / d;
                  e_so  = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b_m[i][pos-1];
                  e_rdy = 1'b0;
                  e_st  = 4'(pos + 1);
                  e_sym = ((k_m[i] % d) == d - 1);
               end else begin
                  e_so = 1'b1; e_rdy = 1'b1; e_st = 4'd0; e_sym = 1'b0;
               end
               chk($sformatf("line_u%0d", i), {25'd0, so[i], rdy[i], st[i], sym[i]},
                   {25'd0, e_so, e_rdy, e_st, e_sym});

               if (st[i] === 4'd0) begin
                  nb[i] = 0; run[i] = 0;
               end else begin
                  run[i] = (st[i] !== pst[i]) ? 1 : run[i] + 1;
                  if (sym[i] === 1'b1 && nb[i] < 10) begin
                     chk("bit_length", run[i], d);
                     chk("state_order", {28'd0, st[i]}, nb[i] + 1);
                     fr[i][nb[i]] = so[i];
                     nb[i]++;
                     if (nb[i] == 10) begin
                        lastfr[i] = fr[i];
                        rxcnt[i]++;
                        chk("start_bit", {31'd0, fr[i][0]}, 0);
                        chk("stop_bit", {31'd0, fr[i][9]}, 1);
                        if ((i == 0 ? sb0.size() : sb1.size()) > 0) begin
                           exp_b = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                           chk("rx_byte", {24'd0, fr[i][8:1]}, {24'd0, exp_b});
                        end else begin
                           total++; bad++;
                           $display("FAIL rx_unexpected_frame: got %0h expected none u%0d", fr[i][8:1], i);
                        end
                     end
                  end
               end
               pst[i] = st[i];
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] b, output int acc);
      int n = 0;
      valid[i] = 1'b1;
      din[i]   = b;
      if (i == 0) sb0.push_back(b); else sb1.push_back(b);
      while (rdy[i] !== 1'b1 && n < 20 * DIV_A) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", {31'd0, rdy[i]}, 1);
      @(negedge clk);
      acc      = cyc;
      valid[i] = 1'b0;
   endtask

   task automatic wait_ready(input int i, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[i] !== 1'b1 && n < 20 * DIV_A);
   endtask

   task automatic wait_state(input int i, input logic [3:0] s);
      int n = 0;
      while (st[i] !== s && n < 20 * DIV_A) begin
         @(negedge clk);
         n++;
      end
      chk("reach_state", {28'd0, st[i]}, {28'd0, s});
   endtask

   initial begin
      int a, prev, n, r0;
      logic [7:0] rb;
      rst   = '{1'b1, 1'b1};
      valid = '{1'b0, 1'b0};
      din   = '{8'h00, 8'h00};
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = '{1'b0, 1'b0};
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_serial", {31'd0, so[i]}, 1);
         chk("reset_ready", {31'd0, rdy[i]}, 1);
         chk("reset_state", {28'd0, st[i]}, 0);
      end
      repeat (1000) @(negedge clk);
      chk("idle_serial", {31'd0, so[0]}, 1);
      chk("idle_ready", {31'd0, rdy[0]}, 1);
      chk("idle_state", {28'd0, st[0]}, 0);

      // 0xA5 at the default divider
      send(0, 8'hA5, a);
      wait_ready(0, n);
      chk("a5_ready_latency", n, 4340);
      chk("a5_line_bits", {22'd0, lastfr[0]}, {22'd0, 10'b1101001010});
      chk("a5_frames", rxcnt[0], 1);

      // edge bytes back-to-back
      send(0, 8'h00, prev);
      send(0, 8'hFF, a);
      chk("b2b_spacing_a", a - prev, 10 * DIV_A + 1);
      wait_ready(0, n);

      // busy-valid ignored
      r0 = rxcnt[0];
      send(0, 8'h3C, a);
      wait_state(0, 4'd5);
      valid[0] = 1'b1;
      din[0]   = 8'hFF;
      @(negedge clk);
      chk("busy_ready_low", {31'd0, rdy[0]}, 0);
      valid[0] = 1'b0;
      wait_ready(0, n);
      repeat (2 * DIV_A) @(negedge clk);
      chk("busy_no_second", {28'd0, st[0]}, 0);
      chk("busy_one_frame", rxcnt[0], r0 + 1);
      chk("busy_payload", {24'd0, lastfr[0][8:1]}, {24'd0, 8'h3C});

      // reset mid-frame
      send(0, 8'h81, a);
      wait_state(0, 4'd7);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("midrst_serial", {31'd0, so[0]}, 1);
      chk("midrst_ready", {31'd0, rdy[0]}, 1);
      chk("midrst_state", {28'd0, st[0]}, 0);
      void'(sb0.pop_front());
      send(0, 8'h42, a);
      wait_ready(0, n);
      chk("after_rst_payload", {24'd0, lastfr[0][8:1]}, {24'd0, 8'h42});

      // small divider
      send(1, 8'h5A, a);
      wait_ready(1, n);
      chk("small_frame_len", n, 30);
      chk("small_payload", {24'd0, lastfr[1][8:1]}, {24'd0, 8'h5A});
      send(1, 8'h00, prev);
      send(1, 8'hFF, a);
      for (int j = 0; j < 1000; j++) begin
         prev = a;
         rb   = 8'($urandom_range(255, 0));
         send(1, rb, a);
         chk("b2b_spacing_b", a - prev, 10 * DIV_B + 1);
      end
      wait_ready(1, n);
      repeat (5) @(negedge clk);
      chk("sb_empty_a", sb0.size(), 0);
      chk("sb_empty_b", sb1.size(), 0);
      chk("frames_b", rxcnt[1], 1003);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
